parking_slot_tracker: RTL and testbench
=======================================

Name: parking_slot_tracker

Overview:
Slot-occupancy controller for the two-floor car park. It detects entry and exit button events and allocates each entering car to a slot class. It keeps the remaining-slot count per class and drives the remain_flr_* buses consumed by the 7-segment display block. It also drives the entry gate and the full/denied indicators.

Parameters:
CAP_SPEC_0, 2, special (permit) slots on floor 0
CAP_NORM_0, 3, normal slots on floor 0
CAP_1, 5, slots on floor 1 (class-agnostic)
GATE_CYCLES, 4, CLK cycles GATE_OPEN stays high per granted entry (>=1)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
ENTER_REQ  input  1  entry button level, synchronous to CLK
ENTER_SPEC  input  1  1 = car holds special permit (sampled with ENTER_REQ edge)
EXIT_REQ  input  1  exit button level, synchronous to CLK
EXIT_FLR  input  1  floor being vacated (0/1)
EXIT_SPEC  input  1  on floor 0: 1 = special slot vacated; ignored on floor 1
remain_flr_spec_0  output  3  free special slots, floor 0
remain_flr_norm_0  output  3  free normal slots, floor 0
remain_flr_1  output  3  free slots, floor 1
GATE_OPEN  output  1  entry gate open
ASSIGN_FLR  output  1  floor of last granted car
FULL  output  1  no slot free for a normal car (norm_0==0 and flr_1==0)
DENIED  output  1  one-cycle pulse, entry refused

Behaviour:
- Reset, synchronous on RST high: remain_flr_spec_0=CAP_SPEC_0, remain_flr_norm_0=CAP_NORM_0, remain_flr_1=CAP_1. GATE_OPEN=0, ASSIGN_FLR=0, DENIED=0, state=IDLE, edge registers=0. FULL follows its reset-state counts (0 with defaults). RST mid-gate closes the gate immediately and discards any pending entry.
- Edge detect: registered previous level per button. A rising edge is ENTER_REQ=1 in a cycle where prev=0. A held button produces exactly one event.
- FSM states: IDLE, ALLOC, OPEN, DENY.
- IDLE: on an entry edge, latch ENTER_SPEC and go to ALLOC next cycle.
- ALLOC, one cycle: allocate from the current registered counts. Decrement the chosen count at the ALLOC->OPEN edge.
- Allocation for a special car: spec_0 if >0, else norm_0 if >0, else flr_1 if >0, else deny.
- Allocation for a normal car: norm_0 if >0, else flr_1 if >0, else deny. A normal car never takes spec_0.
- On grant, ASSIGN_FLR is set to the allocated floor at the same edge as the decrement.
- OPEN: GATE_OPEN=1 for exactly GATE_CYCLES cycles, then return to IDLE.
- DENY: DENIED=1 for one cycle, then IDLE. Counts are unchanged.
- Latency: GATE_OPEN or DENIED rises 2 cycles after the cycle the entry edge is sampled.
- Entry edges seen outside IDLE are dropped, not queued.
- Exit events are processed in every state. The exit edge increments the addressed count at the next edge:
  - EXIT_FLR=1 -> flr_1
  - EXIT_FLR=0, EXIT_SPEC=1 -> spec_0
  - EXIT_FLR=0, EXIT_SPEC=0 -> norm_0
- An exit addressed to a count already at capacity is ignored (saturate); no wrap-around.
- Simultaneous exit and ALLOC decrement on the same count: net change 0. On different counts, both apply.
- ALLOC decides on the pre-exit value, so a slot freed in that same cycle is not visible to the decision.
- FULL is combinational from the registered counts.
- Counts never exceed their CAP and never underflow below 0.

Optional Feature:
Macro PARK_EXIT_ERR_EN.
- Defined: adds output port EXIT_ERR (1 bit), reset 0. It pulses high for one cycle when an exit edge is ignored due to saturation.
- Not defined: the port is absent and ignored exits are silent.
- Count behaviour is identical in both builds.

Test Plan:
- RST high 1 cycle -> counts 2/3/5, GATE_OPEN=0, FULL=0, DENIED=0.
- Normal entry edge -> GATE_OPEN high 2 cycles later for 4 cycles, norm_0=2, ASSIGN_FLR=0. Holding ENTER_REQ for 10 cycles yields a single grant.
- 3 normal entries then 5 more normal entries -> norm_0=0 then flr_1=0 and FULL=1. 9th normal entry -> DENIED pulse, counts unchanged. Special entry then -> spec_0 2->1.
- With spec_0=0 and norm_0=1, special entry -> norm_0=0, ASSIGN_FLR=0.
- Exit EXIT_FLR=1 with flr_1=5 -> stays 5 (EXIT_ERR pulse if PARK_EXIT_ERR_EN). Exit floor 0 normal in the same cycle as ALLOC decrements norm_0 -> norm_0 unchanged.
- Entry edge during OPEN -> ignored, no second grant. RST asserted during OPEN -> GATE_OPEN=0 next cycle, counts back to capacity.

Source files
------------

// File: rtl/parking_slot_tracker.sv
// Slot-occupancy controller for the two-floor car park.
// Optional EXIT_ERR port: define PARK_EXIT_ERR_EN.
module parking_slot_tracker #(
    parameter int CAP_SPEC_0  = 2,
    parameter int CAP_NORM_0  = 3,
    parameter int CAP_1       = 5,
    parameter int GATE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENTER_REQ,
    input  logic       ENTER_SPEC,
    input  logic       EXIT_REQ,
    input  logic       EXIT_FLR,
    input  logic       EXIT_SPEC,
    output logic [2:0] remain_flr_spec_0,
    output logic [2:0] remain_flr_norm_0,
    output logic [2:0] remain_flr_1,
    output logic       GATE_OPEN,
    output logic       ASSIGN_FLR,
    output logic       FULL,
    output logic       DENIED
`ifdef PARK_EXIT_ERR_EN
    ,
    output logic       EXIT_ERR
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        OPEN  = 2'd2,
        DENY  = 2'd3
    } state_t;

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    localparam logic [2:0] CAP_S = 3'(CAP_SPEC_0);
    localparam logic [2:0] CAP_N = 3'(CAP_NORM_0);
    localparam logic [2:0] CAP_F = 3'(CAP_1);

    state_t          state_q;
    state_t          state_d;
    logic            enter_prev;
    logic            exit_prev;
    logic            enter_edge;
    logic            exit_edge;
    logic            spec_q;
    logic [GW-1:0]   gate_cnt;

    logic            dec_s;
    logic            dec_n;
    logic            dec_1;
    logic            grant;
    logic            alloc_flr;

    logic            exit_s;
    logic            exit_n;
    logic            exit_1;
    logic            inc_s;
    logic            inc_n;
    logic            inc_1;

    assign enter_edge = ENTER_REQ & ~enter_prev;
    assign exit_edge  = EXIT_REQ & ~exit_prev;

    // Previous button levels, so a held button yields one event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            enter_prev <= 1'b0;
            exit_prev  <= 1'b0;
        end else begin
            enter_prev <= ENTER_REQ;
            exit_prev  <= EXIT_REQ;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, allocation decision and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        dec_s     = 1'b0;
        dec_n     = 1'b0;
        dec_1     = 1'b0;
        alloc_flr = 1'b0;
        GATE_OPEN = 1'b0;
        DENIED    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enter_edge) begin
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                if (spec_q && remain_flr_spec_0 != 3'd0) begin
                    dec_s = 1'b1;
                end else if (remain_flr_norm_0 != 3'd0) begin
                    dec_n = 1'b1;
                end else if (remain_flr_1 != 3'd0) begin
                    dec_1     = 1'b1;
                    alloc_flr = 1'b1;
                end
                if (dec_s | dec_n | dec_1) begin
                    state_d = OPEN;
                end else begin
                    state_d = DENY;
                end
            end
            OPEN: begin
                GATE_OPEN = 1'b1;
                if (gate_cnt == '0) begin
                    state_d = IDLE;
                end
            end
            DENY: begin
                DENIED  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant = dec_s | dec_n | dec_1;

    // Route an exit edge to the count it frees.
    always_comb begin
        exit_s = 1'b0;
        exit_n = 1'b0;
        exit_1 = 1'b0;
        if (exit_edge) begin
            unique case (1'b1)
                EXIT_FLR:               exit_1 = 1'b1;
                !EXIT_FLR && EXIT_SPEC:  exit_s = 1'b1;
                !EXIT_FLR && !EXIT_SPEC: exit_n = 1'b1;
                default: ;
            endcase
        end
    end

    // A full count only accepts an exit when the same cycle takes a slot.
    assign inc_s = exit_s & ((remain_flr_spec_0 != CAP_S) | dec_s);
    assign inc_n = exit_n & ((remain_flr_norm_0 != CAP_N) | dec_n);
    assign inc_1 = exit_1 & ((remain_flr_1 != CAP_F) | dec_1);

    // Remaining-slot counts: exit adds, grant subtracts, both may cancel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            remain_flr_spec_0 <= CAP_S;
            remain_flr_norm_0 <= CAP_N;
            remain_flr_1      <= CAP_F;
        end else begin
            remain_flr_spec_0 <= remain_flr_spec_0 + 3'(inc_s) - 3'(dec_s);
            remain_flr_norm_0 <= remain_flr_norm_0 + 3'(inc_n) - 3'(dec_n);
            remain_flr_1      <= remain_flr_1 + 3'(inc_1) - 3'(dec_1);
        end
    end

    // Permit flag captured with the accepted entry edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            spec_q <= 1'b0;
        end else if (state_q == IDLE && enter_edge) begin
            spec_q <= ENTER_SPEC;
        end
    end

    // Gate hold timer, loaded during the allocation cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gate_cnt <= '0;
        end else if (state_q == ALLOC) begin
            gate_cnt <= GATE_LAST;
        end else if (state_q == OPEN && gate_cnt != '0) begin
            gate_cnt <= gate_cnt - GW'(1);
        end
    end

    // Floor of the most recent granted car.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ASSIGN_FLR <= 1'b0;
        end else if (grant) begin
            ASSIGN_FLR <= alloc_flr;
        end
    end

    assign FULL = (remain_flr_norm_0 == 3'd0) && (remain_flr_1 == 3'd0);

`ifdef PARK_EXIT_ERR_EN
    logic exit_ign;
    assign exit_ign = exit_edge & ~(inc_s | inc_n | inc_1);

    // One-cycle flag for an exit dropped at a full count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            EXIT_ERR <= 1'b0;
        end else begin
            EXIT_ERR <= exit_ign;
        end
    end
`endif

endmodule

// File: tb/tb_parking_slot_tracker.sv
// Randomized bench for parking_slot_tracker against a
// cycle-indexed behavioural model of the car park.
module tb_parking_slot_tracker;

    localparam int G = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ENTER_REQ = 1'b0;
    logic       ENTER_SPEC = 1'b0;
    logic       EXIT_REQ = 1'b0;
    logic       EXIT_FLR = 1'b0;
    logic       EXIT_SPEC = 1'b0;
    logic [2:0] remain_flr_spec_0;
    logic [2:0] remain_flr_norm_0;
    logic [2:0] remain_flr_1;
    logic       GATE_OPEN;
    logic       ASSIGN_FLR;
    logic       FULL;
    logic       DENIED;
`ifdef PARK_EXIT_ERR_EN
    logic       EXIT_ERR;
`endif

    parking_slot_tracker #(
        .CAP_SPEC_0 (2),
        .CAP_NORM_0 (3),
        .CAP_1      (5),
        .GATE_CYCLES(G)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ENTER_REQ        (ENTER_REQ),
        .ENTER_SPEC       (ENTER_SPEC),
        .EXIT_REQ         (EXIT_REQ),
        .EXIT_FLR         (EXIT_FLR),
        .EXIT_SPEC        (EXIT_SPEC),
        .remain_flr_spec_0(remain_flr_spec_0),
        .remain_flr_norm_0(remain_flr_norm_0),
        .remain_flr_1     (remain_flr_1),
        .GATE_OPEN        (GATE_OPEN),
        .ASSIGN_FLR       (ASSIGN_FLR),
        .FULL             (FULL),
        .DENIED           (DENIED)
`ifdef PARK_EXIT_ERR_EN
        ,
        .EXIT_ERR         (EXIT_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    // Model: index 0 = special floor 0, 1 = normal floor 0, 2 = floor 1.
    int cap[3] = '{2, 3, 5};
    int cnt[3];
    int t;
    int free_at;
    int alloc_t;
    int gate_lo;
    int gate_hi;
    int deny_t;
    bit spec_l;
    bit afl;
    bit pe;
    bit px;
`ifdef PARK_EXIT_ERR_EN
    bit err_exp;
`endif

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d want %0d",
                     tag, t, got, exp);
        end
    endtask

    task automatic model_reset(input int idle_from);
        for (int i = 0; i < 3; i++) cnt[i] = cap[i];
        pe      = 1'b0;
        px      = 1'b0;
        free_at = idle_from;
        alloc_t = -1;
        gate_lo = -1;
        gate_hi = -2;
        deny_t  = -1;
        spec_l  = 1'b0;
        afl     = 1'b0;
`ifdef PARK_EXIT_ERR_EN
        err_exp = 1'b0;
`endif
    endtask

    task automatic check_outputs();
        expect_eq("spec0", 32'(remain_flr_spec_0), cnt[0]);
        expect_eq("norm0", 32'(remain_flr_norm_0), cnt[1]);
        expect_eq("flr1", 32'(remain_flr_1), cnt[2]);
        expect_eq("gate", 32'(GATE_OPEN),
                  32'(t >= gate_lo && t <= gate_hi));
        expect_eq("denied", 32'(DENIED), 32'(t == deny_t));
        expect_eq("full", 32'(FULL), 32'(cnt[1] == 0 && cnt[2] == 0));
        expect_eq("assign_flr", 32'(ASSIGN_FLR), 32'(afl));
`ifdef PARK_EXIT_ERR_EN
        expect_eq("exit_err", 32'(EXIT_ERR), 32'(err_exp));
`endif
    endtask

    task automatic model_step(input bit er, input bit es, input bit xr,
                              input bit xf, input bit xs, input bit rs);
        int  dec;
        int  idx;
        bit  en_e;
        bit  ex_e;
        if (rs) begin
            model_reset(t + 1);
            return;
        end
        dec  = -1;
        en_e = er && !pe;
        ex_e = xr && !px;
        pe   = er;
        px   = xr;
`ifdef PARK_EXIT_ERR_EN
        err_exp = 1'b0;
`endif
        if (t == alloc_t) begin
            if (spec_l && cnt[0] > 0) dec = 0;
            else if (cnt[1] > 0) dec = 1;
            else if (cnt[2] > 0) dec = 2;
            if (dec >= 0) begin
                gate_lo = t + 1;
                gate_hi = t + G;
                free_at = t + G + 1;
                afl     = (dec == 2);
            end else begin
                deny_t  = t + 1;
                free_at = t + 2;
            end
        end
        if (en_e && t >= free_at) begin
            alloc_t = t + 1;
            spec_l  = es;
            free_at = 1 << 30;
        end
        if (ex_e) begin
            idx = xf ? 2 : (xs ? 0 : 1);
            if (cnt[idx] < cap[idx] || dec == idx) cnt[idx]++;
`ifdef PARK_EXIT_ERR_EN
            else err_exp = 1'b1;
`endif
        end
        if (dec >= 0) cnt[dec]--;
    endtask

    task automatic cyc(input bit er, input bit es, input bit xr,
                       input bit xf, input bit xs, input bit rs);
        ENTER_REQ  = er;
        ENTER_SPEC = es;
        EXIT_REQ   = xr;
        EXIT_FLR   = xf;
        EXIT_SPEC  = xs;
        RST        = rs;
        @(negedge CLK);
        check_outputs();
        model_step(er, es, xr, xf, xs, rs);
        @(posedge CLK);
        #1;
        t++;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter(input bit spec);
        cyc(1'b1, spec, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) idle();
    endtask

    initial begin
        bit er;
        bit xr;
        t = 0;
        @(posedge CLK);
        #1;
        t = 1;
        model_reset(t);
        RST = 1'b0;
        expect_eq("rst_spec0", 32'(remain_flr_spec_0), 2);
        expect_eq("rst_norm0", 32'(remain_flr_norm_0), 3);
        expect_eq("rst_flr1", 32'(remain_flr_1), 5);
        expect_eq("rst_gate", 32'(GATE_OPEN), 0);
        expect_eq("rst_full", 32'(FULL), 0);
        expect_eq("rst_denied", 32'(DENIED), 0);

        repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) idle();
        expect_eq("held_norm0", 32'(remain_flr_norm_0), 2);
        expect_eq("held_flr", 32'(ASSIGN_FLR), 0);

        repeat (2) enter(1'b0);
        expect_eq("fill_norm0", 32'(remain_flr_norm_0), 0);
        repeat (5) enter(1'b0);
        expect_eq("fill_flr1", 32'(remain_flr_1), 0);
        expect_eq("fill_full", 32'(FULL), 1);
        enter(1'b0);
        expect_eq("deny_flr1", 32'(remain_flr_1), 0);
        enter(1'b1);
        expect_eq("spec_take", 32'(remain_flr_spec_0), 1);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        enter(1'b1);
        expect_eq("spec_empty", 32'(remain_flr_spec_0), 0);
        enter(1'b1);
        expect_eq("spec_to_norm", 32'(remain_flr_norm_0), 0);
        expect_eq("spec_to_norm_flr", 32'(ASSIGN_FLR), 0);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        expect_eq("sat_flr1", 32'(remain_flr_1), 5);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) idle();
        expect_eq("sim_full_norm0", 32'(remain_flr_norm_0), 3);
        enter(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) idle();
        expect_eq("sim_norm0", 32'(remain_flr_norm_0), 2);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) idle();
        expect_eq("open_drop", 32'(remain_flr_norm_0), 1);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_eq("rst_open_gate", 32'(GATE_OPEN), 0);
        expect_eq("rst_open_norm0", 32'(remain_flr_norm_0), 3);

        er = 1'b0;
        xr = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 9) < 3) er = ~er;
            if ($urandom_range(0, 9) < 3) xr = ~xr;
            cyc(er, 1'($urandom_range(0, 1)), xr,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
